// File: rtl/iecdrv_pkg.sv
// Shared definitions for the IEC drive block: arbiter states and the
// round-robin search helper used to pick the next drive for the SD port.
package iecdrv_pkg;

    localparam int unsigned IECDRV_MAX_DRIVES = 4;

    typedef enum logic [1:0] {
        SD_IDLE,
        SD_REQ,
        SD_XFER,
        SD_DONE
    } sd_arb_state_t;

    // Returns {hit, idx}: first requesting drive after ptr, wrapping modulo ndr.
    function automatic logic [2:0] rr_next(
        input logic [1:0]  ptr,
        input logic [3:0]  req,
        input int unsigned ndr
    );
        logic       hit;
        logic [1:0] idx;
        logic [1:0] cand;
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 1; k <= IECDRV_MAX_DRIVES; k++) begin
            if (k <= ndr) begin
                cand = 2'((32'(ptr) + k) % ndr);
                if (!hit && req[cand]) begin
                    hit = 1'b1;
                    idx = cand;
                end
            end
        end
        return {hit, idx};
    endfunction

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer.
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int unsigned NDR = 2
) (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    always_comb begin
        {valid_o, idx_o} = rr_next(ptr_i, req_i, NDR);
    end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter multiplexing per-drive virtual-disk sector requests
// onto the single host block-device port.
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int unsigned NDR         = 2,
    parameter logic [23:0] REQ_TIMEOUT = 24'd16_000_000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba      [NDR],
    input  logic [5:0]        sd_blk_cnt  [NDR],
    input  logic [NDR-1:0]    sd_rd,
    input  logic [NDR-1:0]    sd_wr,
    output logic [NDR-1:0]    sd_ack,
    input  logic [7:0]        sd_buff_din [NDR],
    output logic [31:0]       host_lba,
    output logic [5:0]        host_blk_cnt,
    output logic              host_rd,
    output logic              host_wr,
    input  logic              host_ack,
    output logic [7:0]        host_buff_din,
    output logic [1:0]        host_drive,
    output logic              busy,
    output logic              timeout_err
);

    sd_arb_state_t  state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [31:0]    lba_q, lba_d;
    logic [5:0]     blk_q, blk_d;
    logic           rd_dir_q, rd_dir_d;
    logic [23:0]    tmo_q, tmo_d;
    logic [NDR-1:0] ack_q, ack_d;

    // Per-drive inputs padded to the maximum drive count so a 2-bit index is always in range.
    logic [31:0]    lba_pad [IECDRV_MAX_DRIVES];
    logic [5:0]     blk_pad [IECDRV_MAX_DRIVES];
    logic [7:0]     din_pad [IECDRV_MAX_DRIVES];
    logic [3:0]     req_pad;
    logic [3:0]     rd_pad;
    logic [NDR-1:0] sel_onehot;
    logic           pick_vld;
    logic [1:0]     pick_idx;

    always_comb begin
        req_pad    = '0;
        rd_pad     = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < IECDRV_MAX_DRIVES; i++) begin
            lba_pad[i] = '0;
            blk_pad[i] = '0;
            din_pad[i] = '0;
        end
        for (int unsigned i = 0; i < NDR; i++) begin
            lba_pad[i]    = sd_lba[i];
            blk_pad[i]    = sd_blk_cnt[i];
            din_pad[i]    = sd_buff_din[i];
            req_pad[i]    = sd_rd[i] | sd_wr[i];
            rd_pad[i]     = sd_rd[i];
            sel_onehot[i] = (2'(i) == sel_q);
        end
    end

    iecdrv_rr_pick #(
        .NDR (NDR)
    ) u_pick (
        .req_i   (req_pad),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SD_IDLE;
            sel_q    <= '0;
            ptr_q    <= 2'(NDR - 1);
            lba_q    <= '0;
            blk_q    <= '0;
            rd_dir_q <= 1'b0;
            tmo_q    <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            lba_q    <= lba_d;
            blk_q    <= blk_d;
            rd_dir_q <= rd_dir_d;
            tmo_q    <= tmo_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        lba_d       = lba_q;
        blk_d       = blk_q;
        rd_dir_d    = rd_dir_q;
        tmo_d       = tmo_q;
        ack_d       = '0;
        timeout_err = 1'b0;
        case (state_q)
            SD_IDLE: begin
                if (pick_vld) begin
                    sel_d    = pick_idx;
                    lba_d    = lba_pad[pick_idx];
                    blk_d    = blk_pad[pick_idx];
                    rd_dir_d = rd_pad[pick_idx];
                    tmo_d    = '0;
                    state_d  = SD_REQ;
                end
            end
            SD_REQ: begin
                // Ack wins over a same-cycle cancel; the drive is already committed.
                if (host_ack) begin
                    ack_d   = sel_onehot;
                    state_d = SD_XFER;
                end else if (!req_pad[sel_q]) begin
                    ptr_d   = sel_q;
                    state_d = SD_IDLE;
                end else if ((REQ_TIMEOUT != '0) && (tmo_q == REQ_TIMEOUT)) begin
                    timeout_err = 1'b1;
                    ptr_d       = sel_q;
                    state_d     = SD_IDLE;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            SD_XFER: begin
                if (host_ack) begin
                    ack_d = sel_onehot;
                end else begin
                    state_d = SD_DONE;
                end
            end
            SD_DONE: begin
                ptr_d   = sel_q;
                state_d = SD_IDLE;
            end
            default: state_d = SD_IDLE;
        endcase
    end

    assign sd_ack        = ack_q;
    assign host_lba      = lba_q;
    assign host_blk_cnt  = blk_q;
    assign host_rd       = (state_q == SD_REQ) &&  rd_dir_q;
    assign host_wr       = (state_q == SD_REQ) && !rd_dir_q;
    assign host_drive    = sel_q;
    assign host_buff_din = din_pad[sel_q];
    assign busy          = (state_q != SD_IDLE);

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Self-checking bench for iecdrv_sd_arbiter (NDR=2, short timeout).
module tb_iecdrv_sd_arbiter;

    localparam int unsigned NDR = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba      [NDR];
    logic [5:0]  sd_blk_cnt  [NDR];
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic [7:0]  sd_buff_din [NDR];
    logic [31:0] host_lba;
    logic [5:0]  host_blk_cnt;
    logic        host_rd;
    logic        host_wr;
    logic        host_ack;
    logic [7:0]  host_buff_din;
    logic [1:0]  host_drive;
    logic        busy;
    logic        timeout_err;

    always #5 clk_sys = ~clk_sys;

    iecdrv_sd_arbiter #(
        .NDR         (NDR),
        .REQ_TIMEOUT (24'd100)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .sd_lba        (sd_lba),
        .sd_blk_cnt    (sd_blk_cnt),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_din   (sd_buff_din),
        .host_lba      (host_lba),
        .host_blk_cnt  (host_blk_cnt),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .host_drive    (host_drive),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    typedef struct packed {
        logic [1:0]  ack;
        logic        hrd;
        logic        hwr;
        logic [1:0]  drv;
        logic        busy;
        logic        to;
        logic [31:0] lba;
        logic [5:0]  blk;
        logic [7:0]  din;
    } obs_t;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        logic       ack;
        obs_t       exp;
        string      tag;
    } vec_t;

    vec_t  vecs[$];
    obs_t  sb[$];
    string sb_tag[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t mk(logic [1:0] ack, logic hrd, logic hwr, logic [1:0] drv,
                                logic bsy, logic to, logic [31:0] lba);
        obs_t o;
        o.ack  = ack;
        o.hrd  = hrd;
        o.hwr  = hwr;
        o.drv  = drv;
        o.busy = bsy;
        o.to   = to;
        o.lba  = lba;
        o.blk  = (lba == 32'h11) ? 6'd3 : (lba == 32'h22) ? 6'd5 : 6'd0;
        o.din  = drv[0] ? 8'hB1 : 8'hA0;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ack  = sd_ack;
        o.hrd  = host_rd;
        o.hwr  = host_wr;
        o.drv  = host_drive;
        o.busy = busy;
        o.to   = timeout_err;
        o.lba  = host_lba;
        o.blk  = host_blk_cnt;
        o.din  = host_buff_din;
        return o;
    endfunction

    task automatic add(string tag, logic [1:0] rd, logic [1:0] wr, logic ack,
                       logic [1:0] eack, logic ehrd, logic ehwr, logic [1:0] edrv,
                       logic ebusy, logic eto, logic [31:0] elba);
        vec_t v;
        v.rd  = rd;
        v.wr  = wr;
        v.ack = ack;
        v.exp = mk(eack, ehrd, ehwr, edrv, ebusy, eto, elba);
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic expect_out(string tag, obs_t e);
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic compare();
        obs_t  g;
        obs_t  e;
        string t;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            g = sample();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got ack=%b rd=%b wr=%b drv=%0d busy=%b to=%b lba=%h blk=%0d din=%h, expected ack=%b rd=%b wr=%b drv=%0d busy=%b to=%b lba=%h blk=%0d din=%h",
                         t, g.ack, g.hrd, g.hwr, g.drv, g.busy, g.to, g.lba, g.blk, g.din,
                         e.ack, e.hrd, e.hwr, e.drv, e.busy, e.to, e.lba, e.blk, e.din);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        sd_lba[0]      = 32'h11;
        sd_lba[1]      = 32'h22;
        sd_blk_cnt[0]  = 6'd3;
        sd_blk_cnt[1]  = 6'd5;
        sd_buff_din[0] = 8'hA0;
        sd_buff_din[1] = 8'hB1;
        sd_rd          = '0;
        sd_wr          = '0;
        host_ack       = 1'b0;

        // Fairness: both drives request continuously, grants 0,1,0,1.
        for (int g = 0; g < 4; g++) begin
            logic [1:0]  d;
            logic [1:0]  oh;
            logic [31:0] l;
            d  = 2'(g % 2);
            oh = (d == 2'd1) ? 2'b10 : 2'b01;
            l  = (d == 2'd1) ? 32'h22 : 32'h11;
            add("fair_req",  2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, d, 1'b1, 1'b0, l);
            add("fair_ack",  2'b11, 2'b00, 1'b1, oh,    1'b0, 1'b0, d, 1'b1, 1'b0, l);
            add("fair_ack",  2'b11, 2'b00, 1'b1, oh,    1'b0, 1'b0, d, 1'b1, 1'b0, l);
            add("fair_done", 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, d, 1'b1, 1'b0, l);
            add("fair_idle", 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, d, 1'b0, 1'b0, l);
        end
        add("quiet", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h22);
        // Single read on drive 0 with a 10-cycle ack.
        add("rd_req", 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        for (int i = 0; i < 10; i++)
            add("rd_ack", (i == 0) ? 2'b01 : 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        add("rd_done", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        add("rd_idle", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11);
        // Read wins when drive 1 raises both.
        add("prio_req",  2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("prio_ack",  2'b10, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("prio_done", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("prio_idle", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h22);
        // Plain write on drive 0.
        add("wr_req",  2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h11);
        add("wr_ack",  2'b00, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        add("wr_done", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        add("wr_idle", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11);
        // Cancel: drive 0 drops before ack, pending drive 1 served next.
        add("cxl_req",  2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11);
        add("cxl_drop", 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11);
        add("cxl_next", 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("cxl_ack",  2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("cxl_done", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22);
        add("cxl_idle", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h22);

        // Reset state, checked while reset is held.
        #12;
        expect_out("reset_state", mk(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0));
        compare();
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            sd_rd    = vecs[i].rd;
            sd_wr    = vecs[i].wr;
            host_ack = vecs[i].ack;
            expect_out(vecs[i].tag, vecs[i].exp);
            step();
            compare();
        end

        // Timeout: drive 0 requests, host never acks; pulse exactly 100 cycles after host_rd rose.
        sd_rd = 2'b01;
        expect_out("to_req", mk(2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11));
        step();
        compare();
        for (int k = 1; k <= 100; k++) begin
            expect_out((k == 100) ? "to_pulse" : "to_wait",
                       mk(2'b00, 1'b1, 1'b0, 2'd0, 1'b1, (k == 100), 32'h11));
            step();
            compare();
        end
        expect_out("to_exit", mk(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11));
        step();
        compare();
        sd_rd = 2'b00;
        expect_out("to_idle", mk(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11));
        step();
        compare();

        // Async reset in XFER clears sd_ack/busy without a clock edge.
        sd_rd = 2'b10;
        expect_out("ar_req", mk(2'b00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22));
        step();
        compare();
        host_ack = 1'b1;
        expect_out("ar_xfer", mk(2'b10, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h22));
        step();
        compare();
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("ar_async", mk(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0));
        compare();
        host_ack = 1'b0;
        sd_rd    = 2'b11;
        @(negedge clk_sys);
        reset_n = 1'b1;
        expect_out("ar_regrant", mk(2'b00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h11));
        step();
        compare();
        sd_rd = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iecdrv_sd_arbiter.md
# iecdrv_sd_arbiter

Multiplexes the per-drive virtual-disk sector requests of the multi-drive C1541 block onto the single host block-device port (HPS/SD image channel). It sits directly downstream of the drive array in the `clk_sys` domain. It grants one drive at a time in round-robin order, forwards that drive's LBA, block count and direction to the host, and routes the host acknowledge back to the granted drive only. Per-drive `sd_buff_din` is multiplexed onto the host write-data path.

## Interface
Parameters:
- `NDR`, default 2: number of drives, legal 1..4. `N = NDR-1`.
- `REQ_TIMEOUT`, default 24'd16_000_000: `clk_sys` cycles a request may wait for `host_ack` before being abandoned. 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `sd_lba[NDR]` in 32: per-drive sector LBA.
- `sd_blk_cnt[NDR]` in 6: per-drive block count minus 1.
- `sd_rd` in [N:0]: per-drive read request level.
- `sd_wr` in [N:0]: per-drive write request level.
- `sd_ack` out [N:0]: per-drive acknowledge. At most one bit is set.
- `sd_buff_din[NDR]` in 8: per-drive write data.
- `host_lba` out 32: LBA latched at grant.
- `host_blk_cnt` out 6: block count latched at grant.
- `host_rd`, `host_wr` out 1: host request. Mutually exclusive.
- `host_ack` in 1: host acknowledge, held high for the whole transfer.
- `host_buff_din` out 8: `sd_buff_din[host_drive]`. Combinational.
- `host_drive` out 2: index of the granted drive, or of the last granted drive.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse when a request is abandoned.

## Operation
- State machine: IDLE, REQ, XFER, DONE.
- **IDLE**
  - Scan drives from `ptr+1` modulo NDR for `sd_rd|sd_wr`.
  - On the first hit: latch drive index, LBA, block count and direction (read wins if both are set). Go to REQ.
- **REQ**
  - `host_rd` or `host_wr` is asserted, and the timeout counter runs.
  - `host_ack`=1: go to XFER. Deassert `host_rd`/`host_wr` in the same transition.
  - The granted drive's request drops before ack (drive reset or cancel): go to IDLE. Nothing is forwarded.
  - The counter reaches `REQ_TIMEOUT`: pulse `timeout_err`, go to IDLE.
  - After either exit above, `ptr` advances to the granted drive so the other drives get service.
- **XFER**
  - `sd_ack[sel]` follows `host_ack`. All other `sd_ack` bits are 0.
  - `host_ack` falls: go to DONE.
- **DONE**
  - Set `ptr <= sel` and go to IDLE.
  - This one-cycle gap guarantees `sd_ack[sel]` is low for at least one cycle before a new grant.
- Requests arriving while not in IDLE are level-held by the drives and are not lost.
- `host_drive` changes only on a grant.
- The `host_lba`/`host_blk_cnt` latches are stable from grant until the next grant.
- Reset values:
  - State IDLE; `ptr = N`, so the first scan starts at drive 0.
  - All outputs 0, except `host_drive` = 0 and `host_buff_din` = `sd_buff_din[0]`.
- Reset mid-transfer: the block returns to IDLE immediately and `sd_ack` clears asynchronously. Host-side recovery belongs to the host.

## Timing
- Request seen in IDLE at cycle t: `host_rd`/`host_wr` high at t+1.
- `host_ack` rise at t: `sd_ack[sel]` high at t+1 (registered). Host request low at t+1.
- `host_ack` fall at t: `sd_ack[sel]` low at t+1. Next grant no earlier than t+3.
- Timeout counter is 24 bits, cleared on entry to REQ. It is compared with `==`, so it has no wrap.
- `host_buff_din` has zero-cycle latency from `host_drive`. The host samples it only during ack.

## Structure
- Shared package `iecdrv_pkg`:
  - state enum `sd_arb_state_t`
  - constant `IECDRV_MAX_DRIVES = 4`
  - function `rr_next(ptr, req, ndr)` returning the {hit, idx} pair.
- The round-robin search is a natural sub-module, `iecdrv_rr_pick`: combinational, 4-bit request vector plus pointer in, valid and index out.
- Everything else (FSM, latches, counter, ack demux) lives in one flat `iecdrv_sd_arbiter`.

## Test plan
- **Single read.** NDR=2, drive 0: `sd_rd`=1, LBA 0x11. Expect `host_rd`=1 one cycle later with `host_lba`=0x11. Ack for 10 cycles: `sd_ack`=2'b01 for 10 cycles, delayed by 1.
- **Fairness.** Both drives request continuously. Expect grants alternate 0,1,0,1 over 4 transfers, `host_drive` toggling accordingly.
- **Read/write priority.** Drive 1 has `sd_rd`=`sd_wr`=1. Expect `host_rd`=1 and `host_wr`=0.
- **Cancel.** Drive 0 drops `sd_rd` in REQ before ack. Expect return to IDLE, no `sd_ack`, no `timeout_err`. A pending drive 1 request is granted next.
- **Timeout.** `REQ_TIMEOUT`=100 and host never acks. Expect `timeout_err` pulse exactly 100 cycles after `host_rd` rose, then `host_rd`=0.
- **Async reset in XFER.** Assert `reset_n`=0 while `host_ack`=1. Expect `sd_ack`=0 and `busy`=0 without a clock edge. After release, the next grant is to drive 0.
